// File: rtl/async_fifo_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_pkg
// Shared types and width helpers for the async FIFO write-side arbiter.
//   arb_state_t : arbiter FSM state (IDLE = free arbitration, LOCKED = owner held)
//   idx_width   : bits needed to name one of REQS requesters (min 1)
//   tag_width   : extra FIFO data bits carrying the source index
//                 (non-zero only when ASYNC_FIFO_ARB_TAG_EN is defined)
//   cnt_width   : bits of the per-grant beat counter, wide enough for MAX_BURST
// Optional feature macro: ASYNC_FIFO_ARB_TAG_EN
// -----------------------------------------------------------------------------
package async_fifo_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  function automatic int idx_width(input int reqs);
    return (reqs > 1) ? $clog2(reqs) : 1;
  endfunction

  function automatic int tag_width(input int reqs);
`ifdef ASYNC_FIFO_ARB_TAG_EN
    return idx_width(reqs);
`else
    return 0;
`endif
  endfunction

  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/async_fifo_rr_pick.sv
// -----------------------------------------------------------------------------
// async_fifo_rr_pick
// Combinational round-robin picker: returns the first asserted valid found when
// scanning i_prio, i_prio+1, ... modulo REQS.
//   i_valid [REQS]  request vector
//   i_prio  [IW]    index with highest priority this cycle
//   o_grant [REQS]  one-hot winner (all zero when nothing is valid)
//   o_idx   [IW]    winner index (0 when nothing is valid)
//   o_any           at least one request is valid
// -----------------------------------------------------------------------------
module async_fifo_rr_pick #(
  parameter int REQS = 4,
  parameter int IW   = 2
) (
  input  logic [REQS-1:0] i_valid,
  input  logic [IW-1:0]   i_prio,
  output logic [REQS-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  always_comb begin
    int  j;
    logic w_found;
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    j       = 0;
    for (int k = 0; k < REQS; k++) begin
      j = (int'(i_prio) + k) % REQS;
      if (!w_found && i_valid[j]) begin
        w_found    = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IW'(j);
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/async_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// async_fifo_write_arbiter
// Shares the write port of one async FIFO among REQS requesters, all in the
// FIFO write clock domain. Round-robin between packets; a multi-beat packet
// keeps the grant until its last beat or until MAX_BURST beats have gone.
//
// Handshake (valid/ready, zero latency): a beat of requester i transfers in the
// cycle where i is granted, p_req_valid[i]=1 and p_write_full=0. In that cycle
// p_req_ready[i]=1, p_write_en=1 and p_write_data carries the beat. Requesters
// keep valid/data/last stable until they see ready.
//
// Ports
//   write_clk, write_rst  clock, asynchronous active-high reset
//   p_req_valid/data/last per-requester beat (data flattened REQS x BITS)
//   p_req_ready           per-requester accept
//   p_write_full          FIFO full
//   p_write_en/data       FIFO write port (data widened by the index when tagging)
//   p_grant_id            source of the current write (0 when no write)
//   p_busy                1 while a packet holds the lock
//   p_dbg_state           FSM state (1 = LOCKED)
//   p_dbg_beat_cnt        beats taken in the current locked grant
// Optional feature macro: ASYNC_FIFO_ARB_TAG_EN (prefix data with source index)
// -----------------------------------------------------------------------------
module async_fifo_write_arbiter
  import async_fifo_pkg::*;
#(
  parameter  int BITS      = 32,
  parameter  int REQS      = 4,
  parameter  int MAX_BURST = 8,
  localparam int IW        = idx_width(REQS),
  localparam int OW        = BITS + tag_width(REQS),
  localparam int CW        = cnt_width(MAX_BURST)
) (
  input  logic                 write_clk,
  input  logic                 write_rst,
  input  logic [REQS-1:0]      p_req_valid,
  input  logic [REQS*BITS-1:0] p_req_data,
  input  logic [REQS-1:0]      p_req_last,
  output logic [REQS-1:0]      p_req_ready,
  input  logic                 p_write_full,
  output logic                 p_write_en,
  output logic [OW-1:0]        p_write_data,
  output logic [IW-1:0]        p_grant_id,
  output logic                 p_busy,
  output logic                 p_dbg_state,
  output logic [CW-1:0]        p_dbg_beat_cnt
);

  arb_state_t    r_state, w_state_nxt;
  logic [IW-1:0] r_prio, w_prio_nxt;
  logic [IW-1:0] r_owner, w_owner_nxt;
  logic [CW-1:0] r_beat_cnt, w_cnt_nxt;

  logic [REQS-1:0] w_pick_grant;
  logic [IW-1:0]   w_pick_idx;
  logic            w_pick_any;

  logic [IW-1:0]   w_sel_idx;
  logic [REQS-1:0] w_sel_onehot;
  logic            w_sel_valid;
  logic            w_sel_last;
  logic [BITS-1:0] w_sel_data;
  logic [OW-1:0]   w_out_data;
  logic [IW-1:0]   w_wrap_idx;
  logic            w_xfer;

  // Picker result is only used while IDLE; a locked owner bypasses it.
  async_fifo_rr_pick #(.REQS(REQS), .IW(IW)) u_pick (
    .i_valid (p_req_valid),
    .i_prio  (r_prio),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  always_comb begin
    if (r_state == ARB_LOCKED) begin
      w_sel_idx    = r_owner;
      w_sel_onehot = REQS'(1) << r_owner;
      w_sel_valid  = p_req_valid[r_owner];
    end else begin
      w_sel_idx    = w_pick_idx;
      w_sel_onehot = w_pick_grant;
      w_sel_valid  = w_pick_any;
    end
    w_sel_last = p_req_last[w_sel_idx];
    w_sel_data = p_req_data[w_sel_idx*BITS +: BITS];
    w_wrap_idx = (w_sel_idx == IW'(REQS-1)) ? '0 : w_sel_idx + 1'b1;
    // Reset gates the transfer so the FIFO never sees a write while held.
    w_xfer     = w_sel_valid & ~p_write_full & ~write_rst;
`ifdef ASYNC_FIFO_ARB_TAG_EN
    w_out_data = {w_sel_idx, w_sel_data};
`else
    w_out_data = w_sel_data;
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_beat_cnt;
    case (r_state)
      ARB_IDLE: begin
        if (w_xfer) begin
          if (w_sel_last || MAX_BURST == 1) begin
            w_prio_nxt = w_wrap_idx;
          end else begin
            w_state_nxt = ARB_LOCKED;
            w_owner_nxt = w_sel_idx;
            w_cnt_nxt   = CW'(1);
          end
        end
      end
      ARB_LOCKED: begin
        // Owner dropping valid simply waits here; only an accepted beat moves us.
        if (w_xfer) begin
          if (w_sel_last || r_beat_cnt == CW'(MAX_BURST-1)) begin
            w_state_nxt = ARB_IDLE;
            w_prio_nxt  = w_wrap_idx;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_beat_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge write_clk or posedge write_rst) begin
    if (write_rst) begin
      r_state    <= ARB_IDLE;
      r_prio     <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_prio     <= w_prio_nxt;
      r_owner    <= w_owner_nxt;
      r_beat_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    p_write_en     = w_xfer;
    p_req_ready    = w_xfer ? w_sel_onehot : '0;
    p_grant_id     = w_xfer ? w_sel_idx : '0;
    p_write_data   = w_xfer ? w_out_data : '0;
    p_busy         = (r_state == ARB_LOCKED) & ~write_rst;
    p_dbg_state    = (r_state == ARB_LOCKED);
    p_dbg_beat_cnt = r_beat_cnt;
  end

endmodule

// File: tb/tb_async_fifo_write_arbiter.sv
module tb_async_fifo_write_arbiter;

  localparam int BITS      = 32;
  localparam int REQS      = 4;
  localparam int MAX_BURST = 8;
  localparam int IW        = 2;
  localparam int CW        = 4;
`ifdef ASYNC_FIFO_ARB_TAG_EN
  localparam int OW = BITS + IW;
`else
  localparam int OW = BITS;
`endif
  localparam int DEPTH = 32;

  // ---------------- clock / reset ----------------
  logic                 write_clk = 1'b0;
  logic                 write_rst;
  logic [REQS-1:0]      p_req_valid;
  logic [REQS*BITS-1:0] p_req_data;
  logic [REQS-1:0]      p_req_last;
  logic [REQS-1:0]      p_req_ready;
  logic                 p_write_full;
  logic                 p_write_en;
  logic [OW-1:0]        p_write_data;
  logic [IW-1:0]        p_grant_id;
  logic                 p_busy;
  logic                 p_dbg_state;
  logic [CW-1:0]        p_dbg_beat_cnt;

  always #5 write_clk = ~write_clk;

  async_fifo_write_arbiter #(.BITS(BITS), .REQS(REQS), .MAX_BURST(MAX_BURST)) dut (
    .write_clk      (write_clk),
    .write_rst      (write_rst),
    .p_req_valid    (p_req_valid),
    .p_req_data     (p_req_data),
    .p_req_last     (p_req_last),
    .p_req_ready    (p_req_ready),
    .p_write_full   (p_write_full),
    .p_write_en     (p_write_en),
    .p_write_data   (p_write_data),
    .p_grant_id     (p_grant_id),
    .p_busy         (p_busy),
    .p_dbg_state    (p_dbg_state),
    .p_dbg_beat_cnt (p_dbg_beat_cnt)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  int writes_seen = 0;
  logic [39:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- requester stimulus storage ----------------
  logic [BITS-1:0] pk_data [REQS][DEPTH];
  logic            pk_last [REQS][DEPTH];
  int              head [REQS];
  int              tail [REQS];
  logic [REQS-1:0] acc;

  task automatic load(input int r, input int n, input logic [BITS-1:0] base);
    for (int k = 0; k < n; k++) begin
      pk_data[r][tail[r]] = base + BITS'(k);
      pk_last[r][tail[r]] = (k == n-1);
      tail[r]++;
    end
  endtask

  task automatic expect_w(input int r, input logic [BITS-1:0] d);
    exp_q.push_back({8'(r), d});
  endtask

  function automatic bit pending();
    bit p = 0;
    for (int i = 0; i < REQS; i++) if (head[i] != tail[i]) p = 1;
    return p;
  endfunction

  // Requester driver: retires accepted beats and presents the next one.
  initial begin
    p_req_valid = '0;
    p_req_data  = '0;
    p_req_last  = '0;
    for (int i = 0; i < REQS; i++) begin head[i] = 0; tail[i] = 0; end
    acc = '0;
    forever begin
      @(posedge write_clk);
      #1;
      for (int i = 0; i < REQS; i++) begin
        if (acc[i]) head[i]++;
        if (head[i] != tail[i]) begin
          p_req_valid[i] = 1'b1;
          p_req_data[i*BITS +: BITS] = pk_data[i][head[i]];
          p_req_last[i] = pk_last[i][head[i]];
        end else begin
          p_req_valid[i] = 1'b0;
          p_req_data[i*BITS +: BITS] = '0;
          p_req_last[i] = 1'b0;
        end
      end
      acc = '0;
    end
  end

  // ---------------- behavioural model + compare (every cycle) ----------------
  bit m_locked;
  int m_owner, m_prio, m_beats;

  always @(negedge write_clk) begin
    int c;
    bit go, xf;
    logic [OW-1:0] ed;
    logic [39:0] e;
    if (write_rst) begin
      chk("rst_en", p_write_en, 0);
      chk("rst_ready", p_req_ready, 0);
      chk("rst_busy", p_busy, 0);
      chk("rst_data", p_write_data, 0);
      m_locked = 0; m_owner = 0; m_prio = 0; m_beats = 0;
      acc = '0;
    end else begin
      go = 0; c = 0;
      if (m_locked) begin
        c = m_owner; go = p_req_valid[c];
      end else begin
        for (int k = 0; k < REQS; k++) begin
          int j;
          j = (m_prio + k) % REQS;
          if (!go && p_req_valid[j]) begin go = 1; c = j; end
        end
      end
      xf = go && !p_write_full;
`ifdef ASYNC_FIFO_ARB_TAG_EN
      ed = xf ? {IW'(c), p_req_data[c*BITS +: BITS]} : '0;
`else
      ed = xf ? p_req_data[c*BITS +: BITS] : '0;
`endif
      chk("m_write_en", p_write_en, xf);
      chk("m_ready", p_req_ready, xf ? (64'd1 << c) : 64'd0);
      chk("m_grant_id", p_grant_id, xf ? c : 0);
      chk("m_write_data", p_write_data, ed);
      chk("m_busy", p_busy, m_locked);
      chk("m_state", p_dbg_state, m_locked);
      chk("m_beat_cnt", p_dbg_beat_cnt, m_beats);
      if (p_write_en) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_unexpected actual=%0h required=none", p_write_data);
        end else begin
          e = exp_q.pop_front();
          chk("sb_write", {8'(p_grant_id), p_write_data[BITS-1:0]}, e);
        end
      end
      acc = p_req_ready;
      if (xf) begin
        m_beats++;
        if (p_req_last[c] || m_beats == MAX_BURST) begin
          m_locked = 0; m_prio = (c + 1) % REQS; m_beats = 0;
        end else begin
          m_locked = 1; m_owner = c;
        end
      end
    end
  end

  // ---------------- helpers for the directed sequence ----------------
  task automatic step();
    @(posedge write_clk);
    #2;
  endtask

  task automatic wait_drain(input string name, input int max);
    int n = 0;
    while ((exp_q.size() != 0 || pending()) && n < max) begin
      @(posedge write_clk);
      n++;
    end
    checks++;
    if (n >= max) begin
      failures++;
      $display("FAIL %s_timeout actual=%0d_left required=0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) step();
  endtask

  task automatic wait_writes(input string name, input int target, input int max);
    int n = 0;
    while (writes_seen < target && n < max) begin
      @(posedge write_clk);
      n++;
    end
    checks++;
    if (n >= max) begin
      failures++;
      $display("FAIL %s_timeout actual=%0d required=%0d", name, writes_seen, target);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    bit seen;
    write_rst    = 1'b1;
    p_write_full = 1'b0;
    repeat (3) @(posedge write_clk);
    #1;
    chk("reset_en", p_write_en, 0);
    chk("reset_busy", p_busy, 0);
    chk("reset_state", p_dbg_state, 0);
    chk("reset_cnt", p_dbg_beat_cnt, 0);
    #1 write_rst = 1'b0;
    repeat (2) step();

    // Round robin: all valid, single-beat packets -> 0,1,2,3,0,1,2,3
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < REQS; r++) begin
        load(r, 1, 32'h2000_0000 + (r << 24) + p);
        expect_w(r, 32'h2000_0000 + (r << 24) + p);
      end
    wait_drain("rr", 40);

    // Packet lock: req1 five beats while req0/req2 valid
    load(0, 1, 32'h3000_0000); load(0, 1, 32'h3000_0001);
    load(1, 5, 32'h3100_0000);
    load(2, 1, 32'h3200_0000);
    expect_w(0, 32'h3000_0000);
    for (int k = 0; k < 5; k++) expect_w(1, 32'h3100_0000 + k);
    expect_w(2, 32'h3200_0000);
    expect_w(0, 32'h3000_0001);
    wait_drain("lock", 60);

    // Burst cap: req3 twelve beats -> 8, then req0, then remaining 4
    load(0, 1, 32'h4000_0000);
    load(1, 1, 32'h4100_0000);
    load(2, 1, 32'h4200_0000);
    load(3, 12, 32'h4300_0000);
    expect_w(1, 32'h4100_0000);
    expect_w(2, 32'h4200_0000);
    for (int k = 0; k < 8; k++) expect_w(3, 32'h4300_0000 + k);
    expect_w(0, 32'h4000_0000);
    for (int k = 8; k < 12; k++) expect_w(3, 32'h4300_0000 + k);
    wait_drain("cap", 80);

    // Full stall at beat 2 of a 4-beat burst
    base = writes_seen;
    load(0, 4, 32'h5000_0000);
    for (int k = 0; k < 4; k++) expect_w(0, 32'h5000_0000 + k);
    wait_writes("stall_pre", base + 2, 40);
    #2 p_write_full = 1'b1;
    repeat (4) begin
      @(negedge write_clk);
      chk("stall_en", p_write_en, 0);
      chk("stall_ready", p_req_ready, 0);
      chk("stall_cnt", p_dbg_beat_cnt, 2);
      chk("stall_busy", p_busy, 1);
    end
    @(posedge write_clk);
    #2 p_write_full = 1'b0;
    wait_drain("stall", 40);

    // Reset mid-burst: req0 locked after 3 beats, req2 waiting
    base = writes_seen;
    load(0, 6, 32'h6000_0000);
    for (int k = 0; k < 3; k++) expect_w(0, 32'h6000_0000 + k);
    expect_w(2, 32'h6200_0000);
    wait_writes("rstb_first", base + 1, 40);
    load(2, 1, 32'h6200_0000);
    wait_writes("rstb_three", base + 3, 40);
    #2;
    chk("rstb_busy_before", p_busy, 1);
    chk("rstb_cnt_before", p_dbg_beat_cnt, 3);
    write_rst = 1'b1;
    head[0] = tail[0];
    #1;
    chk("rstb_en_now", p_write_en, 0);
    chk("rstb_busy_now", p_busy, 0);
    chk("rstb_cnt_now", p_dbg_beat_cnt, 0);
    repeat (2) @(posedge write_clk);
    #2 write_rst = 1'b0;
    wait_drain("rstb", 40);

    // Single beat with known payload
    load(2, 1, 32'hDEAD_BEEF);
    expect_w(2, 32'hDEAD_BEEF);
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge write_clk);
      if (p_write_en) begin
        seen = 1;
        chk("t6_grant", p_grant_id, 2);
`ifdef ASYNC_FIFO_ARB_TAG_EN
        chk("t6_data", p_write_data, {2'd2, 32'hDEAD_BEEF});
`else
        chk("t6_data", p_write_data, 32'hDEAD_BEEF);
`endif
      end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL t6_timeout actual=no_write required=write");
    end
    wait_drain("t6", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
